// File: rtl/sa_weight_loader.sv
// sa_weight_loader: producer-side sequencer for the systolic array's weight
// delay-line. Collects one SA_SIZE x SA_SIZE tile over a valid/ready stream
// into a LIFO buffer, then replays it in reverse order, one weight per
// cycle, with a shift strobe. Reverse replay makes W[0][0] settle in
// PE[0][0] and W[N-1][N-1] in PE[N-1][N-1] once the tile is fully shifted.
//
// Optional build macro: SA_WEIGHT_LOADER_TRANSPOSE_EN
//   defined   -> input taken column-major, transposed on write
//   undefined -> input taken row-major (default)
module sa_weight_loader #(
  parameter int SA_SIZE     = 8,
  parameter int WEIGHT_SIZE = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WEIGHT_SIZE-1:0] w_in,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic                   stall,
  input  logic                   abort,
  output logic [WEIGHT_SIZE-1:0] weight_out,
  output logic                   weight_shift_en,
  output logic                   busy,
  output logic                   done
);

  localparam int DEPTH = SA_SIZE * SA_SIZE;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] SHIFT   = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]             r_state;
  logic [CW-1:0]          r_wrCnt;
  logic [CW-1:0]          r_rdCnt;
  logic [WEIGHT_SIZE-1:0] r_buf [DEPTH];

  logic          w_accept;
  logic          w_shift;
  logic [AW-1:0] w_wrIdx;
  logic [AW-1:0] w_rdIdx;
  logic          w_lastWr;
  logic          w_lastRd;

  // Handshake and shift qualifiers; abort overrides everything combinationally
  assign w_accept = (r_state == COLLECT) && w_valid && !abort;
  assign w_shift  = (r_state == SHIFT) && !stall && !abort;
  assign w_lastWr = (r_wrCnt == CW'(DEPTH - 1));
  assign w_lastRd = (r_rdCnt == CW'(DEPTH - 1));

`ifdef SA_WEIGHT_LOADER_TRANSPOSE_EN
  // Column-major beat k lands at (k mod N)*N + k/N, so the buffer always
  // holds the logical matrix in row-major order.
  assign w_wrIdx = AW'((32'(r_wrCnt) % 32'(SA_SIZE)) * 32'(SA_SIZE)
                       + 32'(r_wrCnt) / 32'(SA_SIZE));
`else
  assign w_wrIdx = r_wrCnt[AW-1:0];
`endif

  // LIFO read pointer: last written entry comes out first
  assign w_rdIdx = AW'(DEPTH - 1) - r_rdCnt[AW-1:0];

  // Outputs are decoded from state so an async reset clears them at once
  assign w_ready         = (r_state == COLLECT) && !abort;
  assign weight_shift_en = w_shift;
  assign weight_out      = w_shift ? r_buf[w_rdIdx] : '0;
  assign busy            = (r_state != COLLECT);
  assign done            = (r_state == DONE) && !abort;

  // Sequencer state and beat counters; abort returns to an empty COLLECT
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= COLLECT;
      r_wrCnt <= '0;
      r_rdCnt <= '0;
    end else if (abort) begin
      r_state <= COLLECT;
      r_wrCnt <= '0;
      r_rdCnt <= '0;
    end else begin
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            r_wrCnt <= r_wrCnt + CW'(1);
            if (w_lastWr) begin
              r_state <= SHIFT;
              r_rdCnt <= '0;
            end
          end
        end
        SHIFT: begin
          if (!stall) begin
            r_rdCnt <= r_rdCnt + CW'(1);
            if (w_lastRd) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= COLLECT;
          r_wrCnt <= '0;
          r_rdCnt <= '0;
        end
        default: begin
          r_state <= COLLECT;
          r_wrCnt <= '0;
          r_rdCnt <= '0;
        end
      endcase
    end
  end

  // Tile storage; contents are only meaningful after a full collect
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[w_wrIdx] <= w_in;
    end
  end

`ifndef SYNTHESIS
  // Shift strobe must only come from the SHIFT state
  assertShiftInShift: assert property (@(posedge clk) disable iff (!resetn)
    weight_shift_en |-> (r_state == SHIFT));

  // Completion is a single-cycle pulse
  assertDonePulse: assert property (@(posedge clk) disable iff (!resetn)
    done |=> !done);
`endif

endmodule

// File: tb/tb_sa_weight_loader.sv
// tb_sa_weight_loader: directed bench for sa_weight_loader with SA_SIZE=2.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// well away from the rising edge where the DUT registers them.
module tb_sa_weight_loader;

  localparam int N     = 2;
  localparam int DEPTH = N * N;
  localparam int W     = 32;

  logic         clk;
  logic         resetn;
  logic [W-1:0] w_in;
  logic         w_valid;
  logic         w_ready;
  logic         stall;
  logic         abort;
  logic [W-1:0] weight_out;
  logic         weight_shift_en;
  logic         busy;
  logic         done;

  int nChecks = 0;
  int nPassed = 0;

  logic [W-1:0] specTile [DEPTH] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
  logic [W-1:0] seqTile  [DEPTH] = '{32'h1, 32'h2, 32'h3, 32'h4};
  logic [W-1:0] togTile  [DEPTH] = '{32'h11, 32'h22, 32'h33, 32'h44};

  sa_weight_loader #(.SA_SIZE(N), .WEIGHT_SIZE(W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .w_in           (w_in),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .stall          (stall),
    .abort          (abort),
    .weight_out     (weight_out),
    .weight_shift_en(weight_shift_en),
    .busy           (busy),
    .done           (done)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Which input beat appears on shift j: reverse replay of the buffer, with
  // the buffer position mapped back through the transpose when enabled.
  function automatic int expBeat(input int j);
    int p;
    p = DEPTH - 1 - j;
`ifdef SA_WEIGHT_LOADER_TRANSPOSE_EN
    return (p % N) * N + p / N;
`else
    return p;
`endif
  endfunction

  task automatic loadTile(input logic [W-1:0] beats [DEPTH]);
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      w_valid = 1'b1;
      w_in    = beats[k];
    end
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    w_in    = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    @(negedge clk);
    #1;
    nChecks++; if (w_ready !== 1'b1) $display("[TB] FAIL reset_w_ready: got %b expected 1", w_ready); else nPassed++;
    nChecks++; if (weight_out !== '0) $display("[TB] FAIL reset_weight_out: got %h expected 0", weight_out); else nPassed++;
    nChecks++; if (weight_shift_en !== 1'b0) $display("[TB] FAIL reset_shift_en: got %b expected 0", weight_shift_en); else nPassed++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else nPassed++;
    nChecks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else nPassed++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    for (int k = 0; k < DEPTH; k++) begin
      @(negedge clk);
      w_valid = 1'b1;
      w_in    = specTile[k];
      #1;
      nChecks++; if (w_ready !== 1'b1) $display("[TB] FAIL basic_accept%0d: w_ready got %b expected 1", k, w_ready); else nPassed++;
      nChecks++; if (weight_shift_en !== 1'b0) $display("[TB] FAIL basic_noshift%0d: got %b expected 0", k, weight_shift_en); else nPassed++;
    end
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge clk);
      #1;
      nChecks++; if (weight_shift_en !== 1'b1) $display("[TB] FAIL basic_shift_en%0d: got %b expected 1", j, weight_shift_en); else nPassed++;
      nChecks++; if (weight_out !== specTile[expBeat(j)]) $display("[TB] FAIL basic_out%0d: got %h expected %h", j, weight_out, specTile[expBeat(j)]); else nPassed++;
      nChecks++; if (w_ready !== 1'b0) $display("[TB] FAIL basic_ready_low%0d: got %b expected 0", j, w_ready); else nPassed++;
    end
    @(negedge clk);
    #1;
    nChecks++; if (done !== 1'b1) $display("[TB] FAIL basic_done: got %b expected 1", done); else nPassed++;
    nChecks++; if (weight_shift_en !== 1'b0) $display("[TB] FAIL basic_done_noshift: got %b expected 0", weight_shift_en); else nPassed++;
    nChecks++; if (busy !== 1'b1) $display("[TB] FAIL basic_done_busy: got %b expected 1", busy); else nPassed++;
    @(negedge clk);
    w_valid = 1'b0;
    #1;
    nChecks++; if (done !== 1'b0) $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); else nPassed++;
    nChecks++; if (w_ready !== 1'b1) $display("[TB] FAIL basic_ready_again: got %b expected 1", w_ready); else nPassed++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL basic_idle: got %b expected 0", busy); else nPassed++;
  endtask

  task automatic test_stall();
    loadTile(specTile);
    for (int j = 0; j < DEPTH + 3; j++) begin
      @(negedge clk);
      stall = (j >= 2 && j < 5);
      #1;
      if (stall) begin
        nChecks++; if (weight_shift_en !== 1'b0) $display("[TB] FAIL stall_shift_en%0d: got %b expected 0", j, weight_shift_en); else nPassed++;
        nChecks++; if (weight_out !== '0) $display("[TB] FAIL stall_out%0d: got %h expected 0", j, weight_out); else nPassed++;
        nChecks++; if (done !== 1'b0) $display("[TB] FAIL stall_done%0d: got %b expected 0", j, done); else nPassed++;
      end else begin
        nChecks++; if (weight_shift_en !== 1'b1) $display("[TB] FAIL stall_resume_en%0d: got %b expected 1", j, weight_shift_en); else nPassed++;
        nChecks++; if (weight_out !== specTile[expBeat(j < 2 ? j : j - 3)]) $display("[TB] FAIL stall_resume_out%0d: got %h expected %h", j, weight_out, specTile[expBeat(j < 2 ? j : j - 3)]); else nPassed++;
      end
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    nChecks++; if (done !== 1'b1) $display("[TB] FAIL stall_done: got %b expected 1", done); else nPassed++;
    @(negedge clk);
    #1;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL stall_idle: got %b expected 0", busy); else nPassed++;
  endtask

  task automatic test_abort();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      w_valid = 1'b1;
      w_in    = 32'hA0 + W'(k);
    end
    @(negedge clk);
    abort = 1'b1;
    #1;
    nChecks++; if (w_ready !== 1'b0) $display("[TB] FAIL abort_ready: got %b expected 0", w_ready); else nPassed++;
    nChecks++; if (weight_shift_en !== 1'b0) $display("[TB] FAIL abort_shift_en: got %b expected 0", weight_shift_en); else nPassed++;
    @(negedge clk);
    abort   = 1'b0;
    w_valid = 1'b0;
    #1;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else nPassed++;
    nChecks++; if (dut.r_wrCnt !== '0) $display("[TB] FAIL abort_wr_cnt: got %0d expected 0", dut.r_wrCnt); else nPassed++;
    loadTile(seqTile);
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge clk);
      #1;
      nChecks++; if (weight_shift_en !== 1'b1) $display("[TB] FAIL abort_reload_en%0d: got %b expected 1", j, weight_shift_en); else nPassed++;
      nChecks++; if (weight_out !== seqTile[expBeat(j)]) $display("[TB] FAIL abort_reload_out%0d: got %h expected %h", j, weight_out, seqTile[expBeat(j)]); else nPassed++;
    end
    @(negedge clk);
    #1;
    nChecks++; if (done !== 1'b1) $display("[TB] FAIL abort_reload_done: got %b expected 1", done); else nPassed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_shift();
    loadTile(specTile);
    @(negedge clk);
    #1;
    nChecks++; if (weight_shift_en !== 1'b1) $display("[TB] FAIL rst_first_shift: got %b expected 1", weight_shift_en); else nPassed++;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    nChecks++; if (weight_shift_en !== 1'b0) $display("[TB] FAIL rst_shift_en: got %b expected 0", weight_shift_en); else nPassed++;
    nChecks++; if (weight_out !== '0) $display("[TB] FAIL rst_out: got %h expected 0", weight_out); else nPassed++;
    nChecks++; if (w_ready !== 1'b1) $display("[TB] FAIL rst_ready: got %b expected 1", w_ready); else nPassed++;
    nChecks++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", busy); else nPassed++;
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < DEPTH + 2; c++) begin
      @(negedge clk);
      #1;
      nChecks++; if (done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL rst_no_done%0d: done %b busy %b expected 0 0", c, done, busy); else nPassed++;
    end
  endtask

  task automatic test_toggle_valid();
    int accepts;
    int cyc;
    accepts = 0;
    for (int i = 0; i < 2 * DEPTH - 1; i++) begin
      @(negedge clk);
      w_valid = (i % 2 == 0);
      w_in    = togTile[i / 2];
      #1;
      if (w_valid && w_ready) accepts++;
      nChecks++; if (weight_shift_en !== 1'b0) $display("[TB] FAIL toggle_noshift%0d: got %b expected 0", i, weight_shift_en); else nPassed++;
    end
    nChecks++; if (accepts !== DEPTH) $display("[TB] FAIL toggle_accepts: got %0d expected %0d", accepts, DEPTH); else nPassed++;
    @(negedge clk);
    w_valid = 1'b0;
    #1;
    nChecks++; if (weight_shift_en !== 1'b1) $display("[TB] FAIL toggle_first_shift: got %b expected 1", weight_shift_en); else nPassed++;
    nChecks++; if (weight_out !== togTile[expBeat(0)]) $display("[TB] FAIL toggle_first_out: got %h expected %h", weight_out, togTile[expBeat(0)]); else nPassed++;
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    nChecks++; if (cyc !== DEPTH) $display("[TB] FAIL toggle_done_latency: got %0d cycles expected %0d", cyc, DEPTH); else nPassed++;
    @(negedge clk);
  endtask

  initial begin
    resetn  = 1'b0;
    w_in    = '0;
    w_valid = 1'b0;
    stall   = 1'b0;
    abort   = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_reset_mid_shift();
    test_toggle_valid();
    $display("%0d/%0d checks passed", nPassed, nChecks);
    $finish;
  end

endmodule
